// File: rtl/addend_collector.sv
`default_nettype none
// ============================================================================
//  Module      : addend_collector
//  Description : Serial-to-packed front end for the adder tree. Accepts one
//                signed addend per cycle on a valid/ready stream, packs up to
//                LENGTH addends little-endian into one vector and keeps a
//                running signed sum. Packed vector, sum and beat count are
//                presented together as one frame on a valid/ready output.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                in_valid/in_ready       - input beat handshake
//                in_data, in_last        - signed addend, early frame close
//                out_valid/out_ready     - output frame handshake
//                out_addends             - packed slots, slot k at [k*DW +: DW]
//                out_sum                 - signed sum of all slots
//                out_count               - beats in the frame (1..LENGTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module addend_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int LENGTH     = 8,
    parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(LENGTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LENGTH*DATA_WIDTH-1:0] out_addends,
    output logic [OUT_WIDTH-1:0]         out_sum,
    output logic [$clog2(LENGTH+1)-1:0]  out_count
);

    localparam int         c_cnt_w   = $clog2(LENGTH + 1);
    localparam logic [0:0] c_collect = 1'b0;
    localparam logic [0:0] c_hold    = 1'b1;

    logic [0:0]                   state_q,  state_d;
    logic [LENGTH*DATA_WIDTH-1:0] slots_q,  slots_d;
    logic signed [OUT_WIDTH-1:0]  acc_q,    acc_d;
    logic [c_cnt_w-1:0]           idx_q,    idx_d;

    logic                         w_accept;
    logic signed [OUT_WIDTH-1:0]  w_ext;

    // in_ready depends only on state and out_ready, never on in_valid.
    assign w_accept = in_valid && in_ready;
    assign w_ext    = OUT_WIDTH'($signed(in_data));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_collect;
            slots_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            slots_q <= slots_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        slots_d = slots_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        case (state_q)
            c_collect: begin
                if (w_accept) begin
                    for (int k = 0; k < LENGTH; k++) begin
                        if (idx_q == c_cnt_w'(k)) begin
                            slots_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                        end
                    end
                    acc_d = acc_q + w_ext;
                    idx_d = idx_q + c_cnt_w'(1);
                    if ((idx_q == c_cnt_w'(LENGTH - 1)) || in_last) begin
                        state_d = c_hold;
                    end
                end
            end
            default: begin
                // Handoff. Clearing all slots keeps unused slots of an
                // early-closed frame at zero, so the sum matches the slots.
                if (out_ready) begin
                    slots_d = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = c_collect;
                    // A beat arriving on the handoff cycle opens the next frame.
                    if (w_accept) begin
                        slots_d[DATA_WIDTH-1:0] = in_data;
                        acc_d   = w_ext;
                        idx_d   = c_cnt_w'(1);
                        if ((LENGTH == 1) || in_last) begin
                            state_d = c_hold;
                        end
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        out_valid   = (state_q == c_hold);
        in_ready    = (state_q == c_collect) || out_ready;
        out_addends = slots_q;
        out_sum     = acc_q;
        out_count   = idx_q;
    end

endmodule
`default_nettype wire

// File: doc/addend_collector.md
# addend_collector

Serial-to-packed front end for the adder tree datapath. Accepts one signed DATA_WIDTH addend per cycle over a valid/ready stream and packs LENGTH addends into the same little-endian packed vector format the adder tree consumes. It keeps a running signed sum alongside the packed vector and presents both as one frame on a valid/ready output. It sits between a serial sample source and any packed-addend consumer, and also provides a reference sum for cross-checking the combinational tree.

## Interface
- DATA_WIDTH, 32, width of one signed addend
- LENGTH, 8, addends per frame (≥1)
- OUT_WIDTH, DATA_WIDTH+$clog2(LENGTH), width of out_sum
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  collector can accept a beat
- in_data  input  DATA_WIDTH  signed addend
- in_last  input  1  beat closes frame early
- out_valid  output  1  frame available
- out_ready  input  1  consumer takes frame
- out_addends  output  LENGTH*DATA_WIDTH  packed frame, slot k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
- out_sum  output  OUT_WIDTH  signed sum of all slots
- out_count  output  $clog2(LENGTH+1)  number of beats in the frame (1..LENGTH)

## Operation
- States: COLLECT (reset state) and HOLD.
- Accept = in_valid && in_ready. in_ready = (state==COLLECT) || out_ready.
- COLLECT: an accepted beat writes in_data to slot idx, adds sign-extended in_data to acc, and increments idx. If idx==LENGTH-1 or in_last is set, go to HOLD. Otherwise stay in COLLECT.
- HOLD: out_valid=1. out_addends, out_sum=acc and out_count=idx are held stable until the frame is taken.
- Handoff when out_valid && out_ready:
  - Without a simultaneous accept: clear all slots, acc and idx, then go to COLLECT.
  - With a simultaneous accept: the new beat goes into slot 0, all other slots are cleared, acc=sext(in_data) and idx=1. Go to HOLD if LENGTH==1 or in_last is set, else go to COLLECT.
- Early close: slots at or above out_count read as zero, so out_sum always equals the signed sum of the packed slots. This matches the combinational tree of the same parameters.
- Arithmetic: all signed two's complement. Every addend is sign-extended to OUT_WIDTH. No overflow is possible at the default OUT_WIDTH. If OUT_WIDTH is overridden narrower, the result wraps modulo 2^OUT_WIDTH.
- LENGTH==1: every accepted beat closes a frame. in_last has no effect.
- in_last on the LENGTH-th beat is redundant and behaves identically.
- in_data and in_last are ignored when in_valid=0.
- Outside HOLD, out_addends/out_sum/out_count show the partial frame and carry no meaning.

## Timing
- Reset (async assert, sync release) values:
  - state=COLLECT, out_valid=0, in_ready=1.
  - out_addends=0, out_sum=0, out_count=0, idx=0, acc=0.
- No beat is accepted while rst_n=0.
- Reset mid-frame discards the partial frame. The first beat after release lands in slot 0.
- Latency: out_valid rises on the cycle after the closing beat is accepted.
- Throughput: one beat per cycle. With out_ready held high, frames stream with no bubble, because the handoff cycle accepts slot 0 of the next frame.
- Backpressure: in HOLD with out_ready=0, in_ready=0 and all out_* are stable.
- out_valid never drops without a handoff.
- in_ready depends combinationally on out_ready only. There is no combinational path from in_valid to in_ready.

## Test plan
- Frame 1..8 (LENGTH 8, DATA_WIDTH 32), out_ready=1 → out_valid 1 cycle after 8th beat; out_sum=36, out_count=8, slot k = k+1.
- Eight beats of -1 → out_sum = -8 (35-bit 0x7_FFFF_FFF8); eight beats of 0x7FFFFFFF → 0x3_FFFF_FFF8; eight beats of 0x80000000 → -2^34.
- Beats 5, -2, 7 with in_last on the third → out_count=3, out_sum=10, slots 3..7 = 0.
- out_ready held low 5 cycles after a frame completes → in_ready=0 and outputs unchanged. Then assert out_ready with in_valid=1 (data 9) → frame handed off and 9 in slot 0. Continuous stream of 3 frames shows no idle cycle.
- Assert rst_n=0 after 4 beats → out_valid=0, in_ready=1. After release, a frame 1..8 yields sum 36 with no residue.
- LENGTH=1: beats 3, -4 back-to-back with out_ready=1 → two frames, sums 3 and -4, out_count=1 each.
